// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage with single-outstanding imem requests, skid buffer
//               and IF/ID register; drops wrong-path words after redirects.
// Revision    : 1.0
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] c_PC_STEP    = 32'd4;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      r_state,     w_stateNext;
    logic [31:0] r_pcF,       w_pcFNext;
    logic [31:0] r_reqPc,     w_reqPcNext;
    logic [31:0] r_bufInstr,  w_bufInstrNext;
    logic [31:0] r_bufPc,     w_bufPcNext;
    logic [31:0] r_instrD,    w_instrDNext;
    logic [31:0] r_pcD,       w_pcDNext;
    logic        r_kill,      w_killNext;
    logic        r_validD,    w_validDNext;
    logic        w_accept;
    logic        w_loadD;
    logic [31:0] w_redirPc;

    // Gated with rst_n so no request is visible while reset is held.
    assign imem_req  = rst_n & (r_state == ST_REQ) & ~redirect;
    assign imem_addr = r_pcF;
    assign w_accept  = imem_req & imem_ready;
    assign w_redirPc = redirect_pc & c_ALIGN_MASK;

    assign instr_d = r_instrD;
    assign pc_d    = r_pcD;
    assign valid_d = r_validD;

    always_comb begin
        w_stateNext    = r_state;
        w_pcFNext      = r_pcF;
        w_reqPcNext    = r_reqPc;
        w_bufInstrNext = r_bufInstr;
        w_bufPcNext    = r_bufPc;
        w_instrDNext   = r_instrD;
        w_pcDNext      = r_pcD;
        w_killNext     = r_kill;
        w_validDNext   = r_validD;
        w_loadD        = 1'b0;

        case (r_state)
            ST_REQ: begin
                if (w_accept) begin
                    w_reqPcNext = r_pcF;
                    w_pcFNext   = r_pcF + c_PC_STEP;
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    if (r_kill) begin
                        w_killNext  = 1'b0;
                        w_stateNext = ST_REQ;
                    end else if (!stall_d || !r_validD) begin
                        w_instrDNext = imem_rdata;
                        w_pcDNext    = r_reqPc;
                        w_loadD      = 1'b1;
                        w_stateNext  = ST_REQ;
                    end else begin
                        w_bufInstrNext = imem_rdata;
                        w_bufPcNext    = r_reqPc;
                        w_stateNext    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall_d) begin
                    w_instrDNext = r_bufInstr;
                    w_pcDNext    = r_bufPc;
                    w_loadD      = 1'b1;
                    w_stateNext  = ST_REQ;
                end
            end
            default: begin
                w_stateNext = ST_REQ;
            end
        endcase

        if (w_loadD) begin
            w_validDNext = 1'b1;
        end else if (!stall_d) begin
            w_validDNext = 1'b0;
        end

        // A pending response with no arrival yet must be swallowed later via kill.
        if (redirect) begin
            w_pcFNext    = w_redirPc;
            w_validDNext = 1'b0;
            w_instrDNext = r_instrD;
            w_pcDNext    = r_pcD;
            if ((r_state == ST_WAIT) && !imem_valid) begin
                w_stateNext = ST_WAIT;
                w_killNext  = 1'b1;
            end else begin
                w_stateNext = ST_REQ;
                w_killNext  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_REQ;
            r_pcF      <= RESET_PC & c_ALIGN_MASK;
            r_reqPc    <= 32'd0;
            r_bufInstr <= 32'd0;
            r_bufPc    <= 32'd0;
            r_instrD   <= 32'd0;
            r_pcD      <= 32'd0;
            r_kill     <= 1'b0;
            r_validD   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_pcF      <= w_pcFNext;
            r_reqPc    <= w_reqPcNext;
            r_bufInstr <= w_bufInstrNext;
            r_bufPc    <= w_bufPcNext;
            r_instrD   <= w_instrDNext;
            r_pcD      <= w_pcDNext;
            r_kill     <= w_killNext;
            r_validD   <= w_validDNext;
        end
    end

endmodule
`default_nettype wire
